wb_burst_ram: RTL

//  Wishbone B3 slave wrapping a byte-enabled single-port RAM; terminates mem port of the mem arbiter (main memory).

---
 rtl/wb_burst_ram_pkg.sv | 42 ++++
 rtl/wb_burst_ram_ram.sv | 30 +++
 rtl/wb_burst_ram.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_burst_ram_pkg.sv
// Shared Wishbone B3 definitions: cycle-type / burst-type codes, the slave
// FSM state type and the beat-address increment used by burst slaves.
package wb_burst_ram_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

  // Next beat word address of an incrementing burst. Wrapping bursts only
  // increment the low address bits and keep the upper bits of the window.
  // Non-incrementing cycle types keep the address.
  function automatic logic [31:0] wb_next_adr(input logic [31:0] adr,
                                              input logic [2:0]  cti,
                                              input logic [1:0]  bte);
    logic [31:0] nxt;
    nxt = adr;
    if (cti == CTI_INC) begin
      case (bte)
        BTE_LINEAR: nxt = adr + 32'd1;
        BTE_WRAP4:  nxt = {adr[31:2], adr[1:0] + 2'd1};
        BTE_WRAP8:  nxt = {adr[31:3], adr[2:0] + 3'd1};
        BTE_WRAP16: nxt = {adr[31:4], adr[3:0] + 4'd1};
        default:    nxt = adr;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_burst_ram_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port (read-before-write on the same address). Contents have no reset.
module wb_burst_ram_ram #(
  parameter int DW = 32,
  parameter int AW = 13
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   adr,
  input  logic [DW-1:0]   wdat,
  output logic [DW-1:0]   rdat
);

  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdat_q;

  // Byte-masked write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < SW; b++) begin
      if (we[b]) mem_q[adr][b*8 +: 8] <= wdat[b*8 +: 8];
    end
    rdat_q <= mem_q[adr];
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave in front of a byte-enabled single-port RAM. Handles
// classic cycles (two clocks per access) and registered-feedback
// incrementing bursts (linear, wrap4/8/16) at one beat per clock.
module wb_burst_ram
  import wb_burst_ram_pkg::*;
#(
  parameter int    dw        = 32,
  parameter int    MEM_BYTES = 32768,
  parameter string MEMFILE   = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [31:0]     wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int SW    = dw / 8;
  localparam int OB    = $clog2(SW);
  localparam int DEPTH = MEM_BYTES / SW;
  localparam int AW    = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [AW-1:0]   beat_q, beat_d;

  logic            cyc_stb;
  logic            out_of_range;
  logic [AW-1:0]   adr_word;
  logic [31:0]     nxt_full;
  logic [AW-1:0]   beat_nxt;
  logic            unused_nxt_hi;
  logic [AW-1:0]   ram_adr;
  logic [SW-1:0]   ram_we;

  assign cyc_stb      = wb_cyc_i & wb_stb_i;
  assign out_of_range = wb_adr_i >= 32'(MEM_BYTES);
  assign adr_word     = wb_adr_i[AW+OB-1:OB];

  // Linear bursts wrap at the end of memory simply by dropping the carry.
  assign nxt_full      = wb_next_adr(32'(beat_q), CTI_INC, wb_bte_i);
  assign beat_nxt      = nxt_full[AW-1:0];
  assign unused_nxt_hi = ^nxt_full[31:AW];

  // A dropped strobe or cycle masks the registered handshake in the same clock.
  assign wb_ack_o = ack_q & cyc_stb;
  assign wb_err_o = err_q & cyc_stb;
  assign wb_rty_o = 1'b0;

  // Next-state, handshake and beat-address decisions.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_stb) begin
          if (out_of_range) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (wb_cti_i == CTI_INC) begin
            state_d = ST_BURST;
            ack_d   = 1'b1;
            beat_d  = adr_word;
          end else begin
            state_d = ST_CLASSIC;
            ack_d   = 1'b1;
            beat_d  = adr_word;
          end
        end
      end
      ST_CLASSIC: state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      ST_BURST: begin
        // ack_q is always set in BURST, so cyc&stb means this beat is acked.
        if (!cyc_stb || wb_cti_i == CTI_EOB) begin
          state_d = ST_IDLE;
        end else begin
          ack_d  = 1'b1;
          beat_d = beat_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, registered handshake flags and burst beat address.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
    end
  end

  // RAM address: fetch one beat ahead during read bursts so every ack carries
  // data; writes always target the beat currently being acknowledged.
  always_comb begin
    ram_adr = beat_q;
    if (state_q == ST_IDLE) begin
      ram_adr = adr_word;
    end else if (state_q == ST_BURST && !wb_we_i) begin
      ram_adr = beat_nxt;
    end
  end

  assign ram_we = {SW{wb_ack_o & wb_we_i}} & wb_sel_i;

  wb_burst_ram_ram #(
    .DW (dw),
    .AW (AW)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (ram_we),
    .adr  (ram_adr),
    .wdat (wb_dat_i),
    .rdat (wb_dat_o)
  );

endmodule
